// File: rtl/mem_word_sequencer.sv
// Word-to-byte access sequencer: turns each 32-bit load/store into four
// single-byte memory cycles on a byte-wide data memory.
module mem_word_sequencer #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_write_data,
  input  logic [7:0]  mem_read_data,
  output logic        mem_read,
  output logic        mem_write
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_beat;
  logic [1:0]  w_beat_next;
  logic [31:0] r_wdata;
  logic [31:0] w_wdata_next;
  logic [31:0] r_asm;
  logic [31:0] w_asm_next;
  logic [31:0] w_asm_merge;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata_next;
  logic [31:0] r_mem_address;
  logic [31:0] w_addr_next;
  logic [7:0]  w_wlane [4];
  logic        w_last_beat;

  assign w_last_beat = (r_beat == 2'd3);

  // Byte lane gi of the word is transferred on beat LANE_BEAT.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_BEAT = BIG_ENDIAN ? 2'(3 - gi) : 2'(gi);

      assign w_wlane[gi] = BIG_ENDIAN ? r_wdata[31-8*gi -: 8] : r_wdata[8*gi +: 8];
      assign w_asm_merge[8*gi +: 8] = (r_beat == LANE_BEAT) ? mem_read_data
                                                            : r_asm[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    w_wdata_next = r_wdata;
    w_asm_next   = r_asm;
    w_rdata_next = r_rdata;
    w_addr_next  = r_mem_address;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_next = we ? S_WRITE : S_READ;
          w_beat_next  = 2'd0;
          w_wdata_next = wdata;
          w_addr_next  = addr;
        end
      end
      S_READ: begin
        w_asm_next  = w_asm_merge;
        w_beat_next = r_beat + 2'd1;
        if (w_last_beat) begin
          w_state_next = S_DONE;
          w_rdata_next = w_asm_merge;
        end else begin
          w_addr_next = r_mem_address + 32'd1;
        end
      end
      S_WRITE: begin
        w_beat_next = r_beat + 2'd1;
        if (w_last_beat) begin
          w_state_next = S_DONE;
        end else begin
          w_addr_next = r_mem_address + 32'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // mem_address is kept in a register so it holds its last beat address in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_beat        <= 2'd0;
      r_wdata       <= 32'd0;
      r_asm         <= 32'd0;
      r_rdata       <= 32'd0;
      r_mem_address <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_beat        <= w_beat_next;
      r_wdata       <= w_wdata_next;
      r_asm         <= w_asm_next;
      r_rdata       <= w_rdata_next;
      r_mem_address <= w_addr_next;
    end
  end

  assign rdata          = r_rdata;
  assign busy           = (r_state == S_READ) || (r_state == S_WRITE);
  assign done           = (r_state == S_DONE);
  assign mem_read       = (r_state == S_READ);
  assign mem_write      = (r_state == S_WRITE);
  assign mem_address    = r_mem_address;
  assign mem_write_data = (r_state == S_WRITE) ? w_wlane[r_beat] : 8'h00;

endmodule

// File: tb/tb_mem_word_sequencer.sv
// Bench for mem_word_sequencer: big- and little-endian instances share stimulus,
// each with its own byte memory and a byte-array reference model.
module tb_mem_word_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we, clear_mem;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_b, ma_b, rdata_l, ma_l;
  logic        busy_b, done_b, mr_b, mw_b, busy_l, done_l, mr_l, mw_l;
  logic [7:0]  mwd_b, mrd_b, mwd_l, mrd_l;

  logic [7:0] mem_b [0:65535];
  logic [7:0] mem_l [0:65535];
  logic [7:0] mdl_b [0:65535];
  logic [7:0] mdl_l [0:65535];

  mem_word_sequencer #(.BIG_ENDIAN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .mem_address(ma_b),
    .mem_write_data(mwd_b), .mem_read_data(mrd_b), .mem_read(mr_b), .mem_write(mw_b));

  mem_word_sequencer #(.BIG_ENDIAN(1'b0)) dut_l (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_l), .busy(busy_l), .done(done_l), .mem_address(ma_l),
    .mem_write_data(mwd_l), .mem_read_data(mrd_l), .mem_read(mr_l), .mem_write(mw_l));

  assign mrd_b = mem_b[ma_b[15:0]];
  assign mrd_l = mem_l[ma_l[15:0]];

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 65536; i++) begin
        mem_b[i] <= 8'h00;
        mem_l[i] <= 8'h00;
      end
    end else begin
      if (mw_b) mem_b[ma_b[15:0]] <= mwd_b;
      if (mw_l) mem_l[ma_l[15:0]] <= mwd_l;
    end
  end

  int cyc = 0;
  int done_cnt_b = 0;
  int done_cnt_l = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done_b) done_cnt_b++;
    if (done_l) done_cnt_l++;
  end

  int total = 0;
  int bad = 0;
  logic [31:0] last_b = 32'd0;
  logic [31:0] last_l = 32'd0;
  int last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input logic [31:0] w, input int k, input bit be);
    logic [31:0] s;
    s = be ? (w >> (8 * (3 - k))) : (w >> (8 * k));
    return s[7:0];
  endfunction

  function automatic logic [15:0] bidx(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = a + 32'(k);
    return s[15:0];
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a, input bit be);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = be ? mdl_b[bidx(a, k)] : mdl_l[bidx(a, k)];
    return be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
  endfunction

  // Status nibble is {busy, done, mem_read, mem_write}.
  task automatic chk_cycle(input string tag, input logic [3:0] st, input logic [31:0] ma,
                           input logic [7:0] wd_b, input logic [7:0] wd_l,
                           input logic [31:0] rd_b, input logic [31:0] rd_l);
    chk({tag, ".st_b"}, 32'({busy_b, done_b, mr_b, mw_b}), 32'(st));
    chk({tag, ".st_l"}, 32'({busy_l, done_l, mr_l, mw_l}), 32'(st));
    chk({tag, ".addr_b"}, ma_b, ma);
    chk({tag, ".addr_l"}, ma_l, ma);
    chk({tag, ".wd_b"}, 32'(mwd_b), 32'(wd_b));
    chk({tag, ".wd_l"}, 32'(mwd_l), 32'(wd_l));
    chk({tag, ".rdata_b"}, rdata_b, rd_b);
    chk({tag, ".rdata_l"}, rdata_l, rd_l);
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] a);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.mem_b[%h]", tag, bidx(a, k)), 32'(mem_b[bidx(a, k)]), 32'(mdl_b[bidx(a, k)]));
      chk($sformatf("%s.mem_l[%h]", tag, bidx(a, k)), 32'(mem_l[bidx(a, k)]), 32'(mdl_l[bidx(a, k)]));
    end
  endtask

  // One complete access, checked cycle by cycle from accept edge E0 to E5.
  task automatic txn(input string tag, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit use_exp, input logic [31:0] exp_rd,
                     input bit noise, input bit keep, input bit chk_int);
    logic [31:0] eb, el;
    int dn_b0, dn_l0;
    if (w) begin
      eb = last_b;
      el = last_l;
    end else if (use_exp) begin
      eb = exp_rd;
      el = exp_rd;
    end else begin
      eb = model_rd(a, 1'b1);
      el = model_rd(a, 1'b0);
    end
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    dn_b0 = done_cnt_b;
    dn_l0 = done_cnt_l;
    @(posedge clk);
    #1;
    if (chk_int) chk({tag, ".interval"}, 32'(cyc - last_acc), 32'd6);
    last_acc = cyc;
    if (noise) begin
      req = 1'b1; we = 1'b1; addr = 32'h0000_0100; wdata = $urandom;
    end else if (!keep) begin
      req = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      chk_cycle($sformatf("%s.beat%0d", tag, k), w ? 4'b1001 : 4'b1010, a + 32'(k),
                w ? lane(d, k, 1'b1) : 8'h00, w ? lane(d, k, 1'b0) : 8'h00, last_b, last_l);
      @(posedge clk);
      #1;
    end
    chk_cycle({tag, ".done"}, 4'b0100, a + 32'd3, 8'h00, 8'h00, eb, el);
    last_b = eb;
    last_l = el;
    @(posedge clk);
    #1;
    chk_cycle({tag, ".idle"}, 4'b0000, a + 32'd3, 8'h00, 8'h00, eb, el);
    if (!keep) req = 1'b0;
    chk({tag, ".ndone_b"}, 32'(done_cnt_b - dn_b0), 32'd1);
    chk({tag, ".ndone_l"}, 32'(done_cnt_l - dn_l0), 32'd1);
    if (w) begin
      for (int k = 0; k < 4; k++) begin
        mdl_b[bidx(a, k)] = lane(d, k, 1'b1);
        mdl_l[bidx(a, k)] = lane(d, k, 1'b0);
      end
      chk_mem(tag, a);
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn_b0, dn_l0;
    tbl[0] = '{w: 1'b1, a: 32'h0000_0004, d: 32'h1234_5678, exp: 32'h0};
    tbl[1] = '{w: 1'b0, a: 32'h0000_0004, d: 32'h0,         exp: 32'h1234_5678};
    tbl[2] = '{w: 1'b1, a: 32'hFFFF_FFFE, d: 32'hAABB_CCDD, exp: 32'h0};
    tbl[3] = '{w: 1'b0, a: 32'hFFFF_FFFE, d: 32'h0,         exp: 32'hAABB_CCDD};
    tbl[4] = '{w: 1'b1, a: 32'h0000_0010, d: 32'h1122_3344, exp: 32'h0};
    tbl[5] = '{w: 1'b0, a: 32'h0000_0010, d: 32'h0,         exp: 32'h1122_3344};
    for (int i = 0; i < 65536; i++) begin
      mdl_b[i] = 8'h00;
      mdl_l[i] = 8'h00;
    end

    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; clear_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_mem = 1'b0;
    chk_cycle("reset", 4'b0000, 32'd0, 8'h00, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_cycle("post_reset", 4'b0000, 32'd0, 8'h00, 8'h00, 32'd0, 32'd0);

    // Reset during beat 2 of a store: beats 0 and 1 are already committed.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_002C; wdata = 32'hFFFF_0000;
    dn_b0 = done_cnt_b;
    dn_l0 = done_cnt_l;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk_cycle("rst_mid.beat0", 4'b1001, 32'h2C, 8'hFF, 8'h00, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    chk_cycle("rst_mid.beat2", 4'b1001, 32'h2E, 8'h00, 8'hFF, 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk_cycle("rst_mid.async", 4'b0000, 32'd0, 8'h00, 8'h00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_cycle("rst_mid.held", 4'b0000, 32'd0, 8'h00, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cycle("rst_mid.after", 4'b0000, 32'd0, 8'h00, 8'h00, 32'd0, 32'd0);
    chk("rst_mid.ndone_b", 32'(done_cnt_b - dn_b0), 32'd0);
    chk("rst_mid.ndone_l", 32'(done_cnt_l - dn_l0), 32'd0);
    for (int k = 0; k < 2; k++) begin
      mdl_b[bidx(32'h2C, k)] = lane(32'hFFFF_0000, k, 1'b1);
      mdl_l[bidx(32'h2C, k)] = lane(32'hFFFF_0000, k, 1'b0);
    end
    chk_mem("rst_mid", 32'h2C);
    chk("rst_mid.byte2e", 32'(mem_b[16'h002E]), 32'h00);
    chk("rst_mid.byte2d", 32'(mem_b[16'h002D]), 32'hFF);
    last_b = 32'd0;
    last_l = 32'd0;

    for (int i = 0; i < 6; i++)
      txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, !tbl[i].w, tbl[i].exp, 1'b0, 1'b0, 1'b0);
    chk("be_bytes", {mem_b[4], mem_b[5], mem_b[6], mem_b[7]}, 32'h1234_5678);
    chk("le_bytes", {mem_l[4], mem_l[5], mem_l[6], mem_l[7]}, 32'h7856_3412);
    chk("le_bytes10", {mem_l[16'h10], mem_l[16'h11], mem_l[16'h12], mem_l[16'h13]}, 32'h4433_2211);

    // A store request held during a load must be ignored.
    txn("ignored", 1'b0, 32'h0000_002C, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk_mem("ignored", 32'h0000_0100);

    // Request held high continuously: one accept every six cycles.
    txn("b2b0", 1'b0, 32'h0000_0004, 32'd0,         1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    txn("b2b1", 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    txn("b2b2", 1'b0, 32'h0000_0010, 32'd0,         1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    txn("b2b3", 1'b1, 32'h0000_0301, 32'h0BAD_BEEF, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    txn("b2b4", 1'b0, 32'h0000_0300, 32'd0,         1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      bit w;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                      : 32'h0000_0200 + 32'($urandom_range(0, 12));
      w = 1'($urandom_range(0, 1));
      txn($sformatf("rnd%0d", i), w, a, $urandom, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
